prbs_checker: RTL and testbench
===============================

Name: prbs_checker

Overview:
- Serial PRBS checker. It is the receive end of the team's Fibonacci LFSR pattern generator.
- It takes the serialized generator bit stream (one bit per valid cycle) and self-synchronizes its local LFSR to the stream.
- Once locked, it flags and counts every bit that disagrees with the predicted sequence.
- It sits on the link-test path after the deserializer/loopback and feeds the status/debug registers.

Parameters:
- WIDTH, 4, LFSR length in bits.
- TAPS, 4'b1010, feedback mask. Predicted bit = XOR of (state & TAPS). The default matches generator feedback state[3]^state[1].
- LOCK_CNT, 8, consecutive matches (after fill) required to declare lock.
- UNLOCK_CNT, 4, consecutive mismatches while locked that force return to search.
- CNT_W, 16, error counter width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- bit_valid_i  input  1  bit_i is valid this cycle. Only valid cycles advance the checker.
- bit_i  input  1  received serial bit, in generator shift-in order.
- clr_err_i  input  1  synchronous clear of err_cnt_o.
- locked_o  output  1  registered lock status.
- err_o  output  1  one-cycle registered pulse per counted mismatch.
- err_cnt_o  output  CNT_W  saturating mismatch count since reset/clear. Counts only while locked.

Behaviour:
- Reset (reset is asynchronous, active-high; clock is clk):
  - state=SEARCH; shift register, fill counter, match counter and miss counter all zero.
  - locked_o=0, err_o=0, err_cnt_o=0.
- Shift register update: sreg <= {sreg[WIDTH-2:0], b}. Newest bit is at bit 0.
- Prediction: pred = ^(sreg & TAPS), computed on the current sreg at the sampling edge.
- Idle cycles: when bit_valid_i=0, nothing changes, except that err_o deasserts and clr_err_i still acts.
- SEARCH:
  - Every valid bit is shifted in as received (b=bit_i).
  - Fill phase: the first WIDTH valid bits only load sreg; no comparison is made. The fill counter saturates at WIDTH.
  - After fill, each valid bit is compared against pred:
    - Match with sreg != 0: match_cnt++.
    - Mismatch, or sreg == 0: match_cnt=0.
  - When match_cnt reaches LOCK_CNT on an edge, that edge sets state=LOCKED, locked_o=1 and miss_cnt=0.
  - No err_o pulses and no counting occur in SEARCH.
- LOCKED:
  - The local LFSR free-runs on its prediction (b=pred), so a bad received bit does not corrupt the reference.
  - Mismatch (bit_i != pred):
    - err_o=1 on the next cycle, for one cycle.
    - err_cnt_o++, saturating at all-ones.
    - miss_cnt++.
  - Match: miss_cnt=0.
  - When miss_cnt reaches UNLOCK_CNT, that edge sets:
    - state=SEARCH, locked_o=0.
    - fill and match counters cleared. sreg is kept, but a full fill is required again.
  - The unlocking mismatch itself is still counted.
- Error counter:
  - clr_err_i=1 clears err_cnt_o.
  - If clr_err_i and a counted mismatch occur on the same edge, err_cnt_o=1.
  - At saturation the counter holds; err_o still pulses.
- Latency: locked_o, err_o and err_cnt_o all update on the clk edge that samples the valid bit, so they are visible the following cycle. Outputs are registered, with no combinational input-to-output path.
- Reset mid-operation: immediate return to reset values regardless of state. Lock must be fully reacquired after release.
- An all-zero stream never locks (sreg==0 blocks match counting).

Test Plan:
- Reset, then continuous valid generator stream 0,1,1,1,1,0 repeating (defaults) -> locked_o rises in the cycle after the 12th valid bit (4 fill + 8 matches); err_cnt_o=0, err_o never asserts.
- Same stream with bit_valid_i toggled 1/0 every cycle -> lock after exactly 12 valid bits (23 cycles); idle cycles change nothing.
- Locked, invert one bit -> single err_o pulse, err_cnt_o=1, locked_o stays 1, and the next bits match (no error propagation). Invert 3 consecutive bits -> err_cnt_o=4, still locked. Invert 4 consecutive bits -> locked_o=0 after the 4th, err_cnt_o=8; clean stream afterwards -> relock after 12 further valid bits.
- Constant 0 input for 100 valid bits -> locked_o stays 0; constant 1 (predictor 1^1=0 mismatches) -> never locks.
- CNT_W=3, locked, 10 isolated single-bit errors -> err_cnt_o holds at 7 with 10 err_o pulses. clr_err_i asserted on an error edge -> err_cnt_o=1. clr_err_i alone -> 0.
- Assert reset while locked with err_cnt_o=5 -> locked_o, err_o and err_cnt_o go to 0 immediately (asynchronously); after release, relock needs 12 valid bits.

Source files
------------

// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronizes a local Fibonacci LFSR to the received
// stream, then flags and counts every bit that disagrees with the prediction.
module prbs_checker #(
  parameter int               WIDTH      = 4,
  parameter logic [WIDTH-1:0] TAPS       = 4'b1010,
  parameter int               LOCK_CNT   = 8,
  parameter int               UNLOCK_CNT = 4,
  parameter int               CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid_i,
  input  logic             bit_i,
  input  logic             clr_err_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_CNT + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   sreg, sreg_n;
  logic [FILL_W-1:0]  fill_cnt, fill_n;
  logic [MATCH_W-1:0] match_cnt, match_n;
  logic [MISS_W-1:0]  miss_cnt, miss_n;
  logic [CNT_W-1:0]   cnt_n;
  logic               counted;
  logic               pred;

  assign pred     = ^(sreg & TAPS);
  assign locked_o = (state == LOCKED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      sreg      <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      fill_cnt  <= fill_n;
      match_cnt <= match_n;
      miss_cnt  <= miss_n;
      err_o     <= counted;
      err_cnt_o <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    fill_n  = fill_cnt;
    match_n = match_cnt;
    miss_n  = miss_cnt;
    counted = 1'b0;

    if (bit_valid_i) begin
      case (state)
        SEARCH: begin
          sreg_n = {sreg[WIDTH-2:0], bit_i};
          if (fill_cnt != FILL_W'(WIDTH)) begin
            fill_n = fill_cnt + FILL_W'(1);
          end else if ((bit_i == pred) && (sreg != '0)) begin
            if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
              state_n = LOCKED;
              match_n = '0;
              miss_n  = '0;
            end else begin
              match_n = match_cnt + MATCH_W'(1);
            end
          end else begin
            match_n = '0;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so corrupted input never pollutes the reference.
          sreg_n = {sreg[WIDTH-2:0], pred};
          if (bit_i != pred) begin
            counted = 1'b1;
            if (miss_cnt == MISS_W'(UNLOCK_CNT - 1)) begin
              state_n = SEARCH;
              fill_n  = '0;
              match_n = '0;
              miss_n  = '0;
            end else begin
              miss_n = miss_cnt + MISS_W'(1);
            end
          end else begin
            miss_n = '0;
          end
        end
        default: ;
      endcase
    end

    // A clear coinciding with a counted mismatch leaves that mismatch in the count.
    if (clr_err_i) begin
      cnt_n = counted ? CNT_W'(1) : '0;
    end else if (counted && (err_cnt_o != '1)) begin
      cnt_n = err_cnt_o + CNT_W'(1);
    end else begin
      cnt_n = err_cnt_o;
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed and random stimulus against a queue-based
// model of the checker, on a default instance and a 3-bit-counter instance.
module tb_prbs_checker;

  localparam logic [3:0] TAPS_M = 4'b1010;

  logic        clk = 1'b0;
  logic        reset;
  logic        bit_valid_i;
  logic        bit_i;
  logic        clr_err_i;
  logic        locked_o, err_o;
  logic [15:0] err_cnt_o;
  logic        locked_s, err_s;
  logic [2:0]  err_cnt_s;

  prbs_checker dut (
    .clk(clk), .reset(reset), .bit_valid_i(bit_valid_i), .bit_i(bit_i),
    .clr_err_i(clr_err_i), .locked_o(locked_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  prbs_checker #(.CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .bit_valid_i(bit_valid_i), .bit_i(bit_i),
    .clr_err_i(clr_err_i), .locked_o(locked_s), .err_o(err_s), .err_cnt_o(err_cnt_s)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int gen_pos = 0;

  // Model: history of the last 4 reference bits, hist[0] newest.
  bit hist[$];
  int m_fill, m_match, m_miss, m_cnt16, m_cnt3;
  bit m_locked, m_err;

  function automatic bit gen_bit(input int k);
    bit pat[6];
    pat = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    return pat[k % 6];
  endfunction

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < 4; i++) hist.push_back(1'b0);
    m_fill = 0; m_match = 0; m_miss = 0;
    m_cnt16 = 0; m_cnt3 = 0;
    m_locked = 1'b0; m_err = 1'b0;
  endfunction

  function automatic void model_step(input bit v, input bit b, input bit c);
    bit p;
    bit allz;
    bit counted;
    p = 1'b0;
    allz = 1'b1;
    counted = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (TAPS_M[i]) p ^= hist[i];
      if (hist[i]) allz = 1'b0;
    end
    if (v) begin
      if (!m_locked) begin
        if (m_fill < 4) m_fill++;
        else if (b == p && !allz) begin
          m_match++;
          if (m_match == 8) begin
            m_locked = 1'b1; m_match = 0; m_miss = 0;
          end
        end else m_match = 0;
        hist.push_front(b);
      end else begin
        if (b != p) begin
          counted = 1'b1;
          m_miss++;
          if (m_miss == 4) begin
            m_locked = 1'b0; m_fill = 0; m_match = 0; m_miss = 0;
          end
        end else m_miss = 0;
        hist.push_front(p);
      end
      void'(hist.pop_back());
    end
    if (c) begin
      m_cnt16 = counted ? 1 : 0;
      m_cnt3  = counted ? 1 : 0;
    end else if (counted) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt3 < 7) m_cnt3++;
    end
    m_err = counted;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check_output({tag, ".locked"},   32'(locked_o),  32'(m_locked));
    check_output({tag, ".err"},      32'(err_o),     32'(m_err));
    check_output({tag, ".cnt"},      32'(err_cnt_o), 32'(m_cnt16));
    check_output({tag, ".locked_s"}, 32'(locked_s),  32'(m_locked));
    check_output({tag, ".err_s"},    32'(err_s),     32'(m_err));
    check_output({tag, ".cnt_s"},    32'(err_cnt_s), 32'(m_cnt3));
  endtask

  // Called at a negedge; returns at the following negedge after checking.
  task automatic apply_stimulus(input bit v, input bit b, input bit c, input string tag);
    bit_valid_i = v;
    bit_i       = b;
    clr_err_i   = c;
    @(posedge clk);
    model_step(v, b, c);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic send(input bit flip, input bit c, input string tag);
    apply_stimulus(1'b1, gen_bit(gen_pos) ^ flip, c, tag);
    gen_pos++;
  endtask

  task automatic do_reset();
    bit_valid_i = 1'b0; bit_i = 1'b0; clr_err_i = 1'b0;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check_model("reset");
    reset = 1'b0;
  endtask

  initial begin
    int pulses;
    reset = 1'b1; bit_valid_i = 1'b0; bit_i = 1'b0; clr_err_i = 1'b0;
    model_reset();
    @(negedge clk);
    check_output("reset_locked", 32'(locked_o), 32'd0);
    check_output("reset_err",    32'(err_o),    32'd0);
    check_output("reset_cnt",    32'(err_cnt_o), 32'd0);
    reset = 1'b0;

    $display("[TB] continuous stream lock");
    for (int i = 0; i < 11; i++) send(1'b0, 1'b0, "acq");
    check_output("acq_11_unlocked", 32'(locked_o), 32'd0);
    send(1'b0, 1'b0, "acq");
    check_output("acq_12_locked", 32'(locked_o), 32'd1);
    check_output("acq_cnt", 32'(err_cnt_o), 32'd0);

    $display("[TB] gapped stream lock");
    do_reset();
    for (int i = 0; i < 23; i++) begin
      if (i % 2 == 0) send(1'b0, 1'b0, "gap");
      else apply_stimulus(1'b0, 1'($urandom), 1'b0, "gap_idle");
      if (i == 21) check_output("gap_22_unlocked", 32'(locked_o), 32'd0);
    end
    check_output("gap_23_locked", 32'(locked_o), 32'd1);

    $display("[TB] error injection");
    send(1'b1, 1'b0, "inj1");
    check_output("inj1_err", 32'(err_o), 32'd1);
    check_output("inj1_cnt", 32'(err_cnt_o), 32'd1);
    send(1'b0, 1'b0, "inj1_next");
    check_output("inj1_next_err", 32'(err_o), 32'd0);
    for (int i = 0; i < 5; i++) send(1'b0, 1'b0, "clean");
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0, "inj3");
    check_output("inj3_cnt", 32'(err_cnt_o), 32'd4);
    check_output("inj3_locked", 32'(locked_o), 32'd1);
    for (int i = 0; i < 4; i++) send(1'b0, 1'b0, "clean");
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0, "inj4");
    check_output("inj4_unlocked", 32'(locked_o), 32'd0);
    check_output("inj4_cnt", 32'(err_cnt_o), 32'd8);
    for (int i = 0; i < 11; i++) send(1'b0, 1'b0, "relock");
    check_output("relock_11", 32'(locked_o), 32'd0);
    send(1'b0, 1'b0, "relock");
    check_output("relock_12", 32'(locked_o), 32'd1);

    $display("[TB] constant streams");
    do_reset();
    for (int i = 0; i < 100; i++) apply_stimulus(1'b1, 1'b0, 1'b0, "zeros");
    check_output("zeros_unlocked", 32'(locked_o), 32'd0);
    do_reset();
    for (int i = 0; i < 100; i++) apply_stimulus(1'b1, 1'b1, 1'b0, "ones");
    check_output("ones_unlocked", 32'(locked_o), 32'd0);

    $display("[TB] counter saturation");
    do_reset();
    for (int i = 0; i < 12; i++) send(1'b0, 1'b0, "sat_acq");
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      send(1'b1, 1'b0, "sat_err");
      if (err_s === 1'b1) pulses++;
      for (int j = 0; j < 3; j++) send(1'b0, 1'b0, "sat_clean");
    end
    check_output("sat_pulses", 32'(pulses), 32'd10);
    check_output("sat_cnt_s", 32'(err_cnt_s), 32'd7);
    check_output("sat_cnt", 32'(err_cnt_o), 32'd10);
    send(1'b1, 1'b1, "clr_on_err");
    check_output("clr_on_err_cnt_s", 32'(err_cnt_s), 32'd1);
    check_output("clr_on_err_cnt", 32'(err_cnt_o), 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b1, "clr_alone");
    check_output("clr_alone_cnt", 32'(err_cnt_o), 32'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      bit v, flip, c;
      v    = ($urandom_range(0, 3) != 0);
      flip = ($urandom_range(0, 19) == 0);
      c    = ($urandom_range(0, 49) == 0);
      if (v) send(flip, c, "rand");
      else apply_stimulus(1'b0, 1'($urandom), c, "rand_idle");
    end

    $display("[TB] asynchronous reset while locked");
    do_reset();
    for (int i = 0; i < 12; i++) send(1'b0, 1'b0, "ar_acq");
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1'b0, "ar_err");
      for (int j = 0; j < 3; j++) send(1'b0, 1'b0, "ar_clean");
    end
    send(1'b1, 1'b0, "ar_err5");
    check_output("ar_pre_cnt", 32'(err_cnt_o), 32'd5);
    check_output("ar_pre_err", 32'(err_o), 32'd1);
    bit_valid_i = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_output("ar_locked", 32'(locked_o), 32'd0);
    check_output("ar_err", 32'(err_o), 32'd0);
    check_output("ar_cnt", 32'(err_cnt_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 11; i++) send(1'b0, 1'b0, "ar_relock");
    check_output("ar_relock_11", 32'(locked_o), 32'd0);
    send(1'b0, 1'b0, "ar_relock");
    check_output("ar_relock_12", 32'(locked_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
